tmds_period_mux: RTL and testbench

//  Final TMDS stage between the symbol sources and the 10:1 serialisers. Merges pre-encoded video

---
 rtl/tmds_period_mux_pkg.sv | 36 +++
 rtl/tmds_lookahead_delay.sv | 26 ++
 rtl/tmds_period_mux.sv | 127 ++++++++++++
 tb/tb_tmds_period_mux.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/tmds_period_mux_pkg.sv
// rtl/tmds_period_mux_pkg.sv - TMDS symbol constants, period codes and CTL symbol helper
package tmds_period_mux_pkg;

    localparam logic [9:0] CTL_00 = 10'b1101010100;
    localparam logic [9:0] CTL_01 = 10'b0010101011;
    localparam logic [9:0] CTL_10 = 10'b0101010100;
    localparam logic [9:0] CTL_11 = 10'b1010101011;

    localparam logic [9:0] VIDEO_GUARD_CH0   = 10'b1011001100;
    localparam logic [9:0] VIDEO_GUARD_CH1   = 10'b0100110011;
    localparam logic [9:0] VIDEO_GUARD_CH2   = 10'b1011001100;
    localparam logic [9:0] ISLAND_GUARD_CH12 = 10'b0100110011;

    localparam int PREAMBLE_CHARS = 8;
    localparam int GUARD_CHARS    = 2;

    typedef enum logic [2:0] {
        PERIOD_CTL    = 3'd0,
        PERIOD_PRE    = 3'd1,
        PERIOD_GUARD  = 3'd2,
        PERIOD_VIDEO  = 3'd3,
        PERIOD_ISLAND = 3'd4
    } period_t;

    function automatic logic [9:0] ctl_symbol(input logic c1, input logic c0);
        logic [9:0] sym;
        case ({c1, c0})
            2'b00:   sym = CTL_00;
            2'b01:   sym = CTL_01;
            2'b10:   sym = CTL_10;
            default: sym = CTL_11;
        endcase
        return sym;
    endfunction

endpackage

// File: rtl/tmds_lookahead_delay.sv
// rtl/tmds_lookahead_delay.sv - resettable shift register delaying the merged symbol/control bus
module tmds_lookahead_delay #(
    parameter int WIDTH = 95,
    parameter int DEPTH = 10
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stages [DEPTH];

    // Flushing to zero makes every stage look like blanking: DE, island actives and syncs all 0.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
        end else begin
            stages[0] <= din;
            for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
        end
    end

    assign dout = stages[DEPTH-1];

endmodule

// File: rtl/tmds_period_mux.sv
// rtl/tmds_period_mux.sv - merges video, island and control symbols with look-ahead preamble/guard insertion
module tmds_period_mux
    import tmds_period_mux_pkg::*;
#(
    parameter int LOOKAHEAD = 10
) (
    input  logic       pixelClock,
    input  logic       resetN,
    input  logic       hSync,
    input  logic       vSync,
    input  logic       videoEnable,
    input  logic [9:0] videoCh0,
    input  logic [9:0] videoCh1,
    input  logic [9:0] videoCh2,
    input  logic       hbIslandActive,
    input  logic [9:0] hbCh0,
    input  logic [9:0] hbCh1,
    input  logic [9:0] hbCh2,
    input  logic       vbIslandActive,
    input  logic [9:0] vbCh0,
    input  logic [9:0] vbCh1,
    input  logic [9:0] vbCh2,
    output logic [9:0] channel0,
    output logic [9:0] channel1,
    output logic [9:0] channel2,
    output logic [2:0] period,
    output logic       islandCollision
);

    localparam int W = 95;

    logic [W-1:0] bus_in;
    logic [W-1:0] bus_dly;

    assign bus_in = {videoEnable, vSync, hSync, videoCh0, videoCh1, videoCh2,
                     hbIslandActive, hbCh0, hbCh1, hbCh2,
                     vbIslandActive, vbCh0, vbCh1, vbCh2};

    // One extra stage is the input capture; the look-ahead window itself is LOOKAHEAD deep.
    tmds_lookahead_delay #(.WIDTH(W), .DEPTH(LOOKAHEAD + 1)) u_delay (
        .clk    (pixelClock),
        .resetn (resetN),
        .din    (bus_in),
        .dout   (bus_dly)
    );

    logic       d_de, d_vs, d_hs, d_hb, d_vb;
    logic [9:0] d_v0, d_v1, d_v2, d_hb0, d_hb1, d_hb2, d_vb0, d_vb1, d_vb2;

    assign {d_de, d_vs, d_hs, d_v0, d_v1, d_v2,
            d_hb, d_hb0, d_hb1, d_hb2,
            d_vb, d_vb0, d_vb1, d_vb2} = bus_dly;

    logic [3:0] count;
    logic       de_prev;

    always_ff @(posedge pixelClock) begin
        if (!resetN) begin
            count   <= '0;
            de_prev <= 1'b0;
        end else begin
            de_prev <= videoEnable;
            if (videoEnable && !de_prev)
                count <= 4'(LOOKAHEAD);
            else if (count != 4'd0)
                count <= count - 4'd1;
        end
    end

    period_t    nxt_period;
    logic [9:0] nxt_ch0, nxt_ch1, nxt_ch2;
    logic       collide;

    always_comb begin
        nxt_period = PERIOD_CTL;
        nxt_ch0    = ctl_symbol(d_vs, d_hs);
        nxt_ch1    = CTL_00;
        nxt_ch2    = CTL_00;
        if (d_de) begin
            nxt_period = PERIOD_VIDEO;
            nxt_ch0    = d_v0;
            nxt_ch1    = d_v1;
            nxt_ch2    = d_v2;
        end else if (count != 4'd0 && count <= 4'(GUARD_CHARS)) begin
            nxt_period = PERIOD_GUARD;
            nxt_ch0    = VIDEO_GUARD_CH0;
            nxt_ch1    = VIDEO_GUARD_CH1;
            nxt_ch2    = VIDEO_GUARD_CH2;
        end else if (count > 4'(GUARD_CHARS)) begin
            nxt_period = PERIOD_PRE;
            nxt_ch1    = CTL_01;
        end else if (d_hb) begin
            nxt_period = PERIOD_ISLAND;
            nxt_ch0    = d_hb0;
            nxt_ch1    = d_hb1;
            nxt_ch2    = d_hb2;
        end else if (d_vb) begin
            nxt_period = PERIOD_ISLAND;
            nxt_ch0    = d_vb0;
            nxt_ch1    = d_vb1;
            nxt_ch2    = d_vb2;
        end
    end

    // An island that loses to a video-side period, or two islands at once, is a source-side bug.
    assign collide = (d_hb && d_vb) ||
                     ((d_hb || d_vb) && (nxt_period == PERIOD_PRE ||
                                         nxt_period == PERIOD_GUARD ||
                                         nxt_period == PERIOD_VIDEO));

    always_ff @(posedge pixelClock) begin
        if (!resetN) begin
            channel0        <= CTL_00;
            channel1        <= CTL_00;
            channel2        <= CTL_00;
            period          <= PERIOD_CTL;
            islandCollision <= 1'b0;
        end else begin
            channel0        <= nxt_ch0;
            channel1        <= nxt_ch1;
            channel2        <= nxt_ch2;
            period          <= nxt_period;
            islandCollision <= islandCollision | collide;
        end
    end

endmodule

// File: tb/tb_tmds_period_mux.sv
// tb/tb_tmds_period_mux.sv - randomized directed bench for tmds_period_mux against a timeline reference model
module tb_tmds_period_mux;

    localparam int MAXN = 4096;

    logic       pixelClock = 1'b0;
    logic       resetN = 1'b0;
    logic       hSync = 1'b0, vSync = 1'b0, videoEnable = 1'b0;
    logic [9:0] videoCh0 = '0, videoCh1 = '0, videoCh2 = '0;
    logic       hbIslandActive = 1'b0, vbIslandActive = 1'b0;
    logic [9:0] hbCh0 = '0, hbCh1 = '0, hbCh2 = '0;
    logic [9:0] vbCh0 = '0, vbCh1 = '0, vbCh2 = '0;
    logic [9:0] channel0, channel1, channel2;
    logic [2:0] period;
    logic       islandCollision;

    tmds_period_mux dut (
        .pixelClock(pixelClock), .resetN(resetN), .hSync(hSync), .vSync(vSync),
        .videoEnable(videoEnable), .videoCh0(videoCh0), .videoCh1(videoCh1), .videoCh2(videoCh2),
        .hbIslandActive(hbIslandActive), .hbCh0(hbCh0), .hbCh1(hbCh1), .hbCh2(hbCh2),
        .vbIslandActive(vbIslandActive), .vbCh0(vbCh0), .vbCh1(vbCh1), .vbCh2(vbCh2),
        .channel0(channel0), .channel1(channel1), .channel2(channel2),
        .period(period), .islandCollision(islandCollision)
    );

    always #5 pixelClock = ~pixelClock;

    logic       rst_a [MAXN];
    logic       de_a [MAXN], vs_a [MAXN], hs_a [MAXN], hb_a [MAXN], vb_a [MAXN];
    logic [9:0] v0_a [MAXN], v1_a [MAXN], v2_a [MAXN];
    logic [9:0] h0_a [MAXN], h1_a [MAXN], h2_a [MAXN];
    logic [9:0] b0_a [MAXN], b1_a [MAXN], b2_a [MAXN];
    logic [9:0] ctl_tab [4];

    int  n = 0;
    int  checks = 0;
    int  passes = 0;
    logic col_model = 1'b0;

    // Expected output at edge e follows the timeline: the sample taken 11 edges earlier (if no
    // reset intervened) and the distance k to the most recent DE rise picks PRE (1..8) or GUARD (9..10).
    task automatic check_edge(input int e);
        logic [9:0] e0, e1, e2;
        logic [2:0] ep;
        logic       valid, dde, dvs, dhs, dhb, dvb;
        int         src, k;
        src = e - 11;
        if (!rst_a[e]) begin
            e0 = 10'b1101010100; e1 = 10'b1101010100; e2 = 10'b1101010100;
            ep = 3'd0;
            col_model = 1'b0;
        end else begin
            valid = (src >= 0);
            for (int i = (src < 0 ? 0 : src); i < e; i++) if (!rst_a[i]) valid = 1'b0;
            dde = valid && de_a[src];
            dvs = valid && vs_a[src];
            dhs = valid && hs_a[src];
            dhb = valid && hb_a[src];
            dvb = valid && vb_a[src];
            k = 0;
            for (int r = e - 1; r >= e - 10 && r >= 0; r--) begin
                if (!rst_a[r]) break;
                if (de_a[r] && (r == 0 || !rst_a[r-1] || !de_a[r-1])) begin
                    k = e - r;
                    break;
                end
            end
            e0 = ctl_tab[{dvs, dhs}]; e1 = 10'b1101010100; e2 = 10'b1101010100; ep = 3'd0;
            if (dde) begin
                ep = 3'd3; e0 = v0_a[src]; e1 = v1_a[src]; e2 = v2_a[src];
            end else if (k >= 9) begin
                ep = 3'd2; e0 = 10'b1011001100; e1 = 10'b0100110011; e2 = 10'b1011001100;
            end else if (k >= 1) begin
                ep = 3'd1; e1 = 10'b0010101011;
            end else if (dhb) begin
                ep = 3'd4; e0 = h0_a[src]; e1 = h1_a[src]; e2 = h2_a[src];
            end else if (dvb) begin
                ep = 3'd4; e0 = b0_a[src]; e1 = b1_a[src]; e2 = b2_a[src];
            end
            if ((dhb && dvb) || ((dhb || dvb) && ep >= 3'd1 && ep <= 3'd3)) col_model = 1'b1;
        end
        checks++;
        assert (channel0 === e0) passes++;
        else $error("FAIL ch0 edge %0d got %b exp %b", e, channel0, e0);
        checks++;
        assert (channel1 === e1) passes++;
        else $error("FAIL ch1 edge %0d got %b exp %b", e, channel1, e1);
        checks++;
        assert (channel2 === e2) passes++;
        else $error("FAIL ch2 edge %0d got %b exp %b", e, channel2, e2);
        checks++;
        assert (period === ep) passes++;
        else $error("FAIL period edge %0d got %0d exp %0d", e, period, ep);
        checks++;
        assert (islandCollision === col_model) passes++;
        else $error("FAIL collision edge %0d got %b exp %b", e, islandCollision, col_model);
    endtask

    task automatic tick(input logic rn, input logic de, input logic vs, input logic hs,
                        input logic hb, input logic vb);
        resetN = rn; videoEnable = de; vSync = vs; hSync = hs;
        hbIslandActive = hb; vbIslandActive = vb;
        videoCh0 = 10'($urandom); videoCh1 = 10'($urandom); videoCh2 = 10'($urandom);
        hbCh0 = 10'($urandom); hbCh1 = 10'($urandom); hbCh2 = 10'($urandom);
        vbCh0 = 10'($urandom); vbCh1 = 10'($urandom); vbCh2 = 10'($urandom);
        @(posedge pixelClock);
        rst_a[n] = rn; de_a[n] = de; vs_a[n] = vs; hs_a[n] = hs; hb_a[n] = hb; vb_a[n] = vb;
        v0_a[n] = videoCh0; v1_a[n] = videoCh1; v2_a[n] = videoCh2;
        h0_a[n] = hbCh0; h1_a[n] = hbCh1; h2_a[n] = hbCh2;
        b0_a[n] = vbCh0; b1_a[n] = vbCh1; b2_a[n] = vbCh2;
        #1;
        check_edge(n);
        n++;
    endtask

    task automatic run(input int len, input logic de, input logic vs, input logic hs,
                       input logic hb, input logic vb);
        for (int i = 0; i < len; i++) tick(1'b1, de, vs, hs, hb, vb);
    endtask

    initial begin
        ctl_tab[0] = 10'b1101010100;
        ctl_tab[1] = 10'b0010101011;
        ctl_tab[2] = 10'b0101010100;
        ctl_tab[3] = 10'b1010101011;

        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        run(20, 0, 0, 0, 0, 0);
        run(40, 1, 0, 0, 0, 0);
        run(20, 0, 0, 1, 0, 0);

        run(15, 0, 1, 0, 0, 0);
        run(36, 0, 1, 0, 0, 1);
        run(20, 0, 1, 0, 0, 0);

        run(20, 0, 0, 0, 0, 0);
        run(20, 1, 0, 0, 0, 0);
        run(4, 0, 0, 1, 0, 0);
        run(20, 1, 0, 0, 0, 0);
        run(20, 0, 0, 0, 0, 0);

        run(5, 1, 0, 0, 0, 0);
        tick(1'b0, 1'b0, 0, 0, 0, 0);
        run(25, 0, 0, 0, 0, 0);

        for (int s = 0; s < 24; s++) begin
            int         kind;
            logic       vs, hs;
            kind = int'($urandom_range(0, 3));
            vs = 1'($urandom); hs = 1'($urandom);
            case (kind)
                0: run(int'($urandom_range(10, 30)), 1, vs, hs, 0, 0);
                1: run(int'($urandom_range(1, 25)), 0, vs, hs, 0, 0);
                2: run(int'($urandom_range(4, 20)), 0, vs, hs, 1, 0);
                default: run(int'($urandom_range(4, 20)), 0, vs, hs, 0, 1);
            endcase
        end

        tick(1'b0, 0, 0, 0, 0, 0);
        tick(1'b0, 0, 0, 0, 0, 0);
        run(20, 0, 0, 0, 0, 0);
        run(2, 0, 0, 0, 1, 0);
        run(1, 0, 0, 0, 1, 1);
        run(3, 0, 0, 0, 1, 0);
        run(30, 0, 0, 0, 0, 0);
        run(40, 1, 0, 0, 0, 0);
        run(15, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
